lifo_stack: RTL and testbench
=============================

# lifo_stack

Parameterised LIFO stack that pairs a write side (push) with a registered read side (pop) for the FRANK6000 datapath; it holds return addresses and operand spills. It is clocked on the rising edge, with an asynchronous active-low reset. Stack contents are internal memory; the popped word is presented on a registered output.

## Interface

**Parameters**
- `width`, default 8: data word width in bits.
- `depth`, default 16: number of entries; must be a power of two, ≥ 2.
- `addr_width`, default 4: log2(`depth`); the integrator sets it consistently.

**Ports**
- `clk`, input, 1: single clock, rising edge active.
- `rst`, input, 1: reset, asynchronous and active-low.
- `D`, input, `width`: data to push.
- `push`, input, 1: push request, sampled at the rising edge.
- `pop`, input, 1: pop request, sampled at the rising edge.
- `Q`, output, `width`: registered popped word.
- `count`, output, `addr_width+1`: number of stored entries, 0..`depth`.
- `empty`, output, 1: high when `count` == 0.
- `full`, output, 1: high when `count` == `depth`.
- `err`, output, 1: sticky error flag for overflow or underflow.

## Operation

**State**
- Stack pointer `sp` (`addr_width+1` bits) = `count`.
- Memory `mem[0..depth-1]`.
- Registers `Q` and `err`.

**Reset** (`rst` low, asynchronous, takes effect immediately and overrides everything)
- `sp` = 0, `Q` = 0, `err` = 0.
- Therefore `count` = 0, `empty` = 1, `full` = 0.
- Memory is not cleared.

**Rising edge, `rst` high; exactly one case applies**
- Idle (`push` = 0, `pop` = 0): no change.
- Push (`push` = 1, `pop` = 0, not full): `mem[sp]` ← `D`; `sp` ← `sp+1`. `Q` unchanged.
- Overflow (`push` = 1, `pop` = 0, full): memory and `sp` unchanged; `err` ← 1.
- Pop (`push` = 0, `pop` = 1, not empty): `Q` ← `mem[sp-1]`; `sp` ← `sp-1`.
- Underflow (`push` = 0, `pop` = 1, empty): `Q` and `sp` unchanged; `err` ← 1.
- Swap (`push` = 1, `pop` = 1, not empty): `Q` ← old `mem[sp-1]`; `mem[sp-1]` ← `D`; `sp` unchanged. Never sets `err`, including when full.
- Pass-through (`push` = 1, `pop` = 1, empty): `Q` ← `D`; `sp` stays 0; memory untouched; no `err`.

**Flags and arithmetic**
- `err` stays high until reset; nothing else clears it.
- `empty`, `full` and `count` are combinational decodes of the `sp` register; they never depend on `push`/`pop` directly.
- `sp` never wraps: no increment at `depth`, no decrement at 0.
- Memory index uses `sp[addr_width-1:0]`; index `sp-1` is only used when `sp` ≥ 1.

## Timing

**Latency**
- Push: the word is stored at edge N and can be popped at edge N+1; after that pop it appears on `Q`.
- Pop: `Q` is valid right after the sampling edge, a one-edge registered latency with no combinational path from `pop` to `Q`.
- Swap: the new top is visible to a pop at the next edge.

**Flags**
- `count`, `empty`, `full` and `err` settle right after the edge that changes `sp`.

**Requests**
- No handshake: every request is consumed at the edge where it is sampled.
- Requests held high for k cycles perform k operations.

**Reset timing**
- Reset asserted mid-operation clears outputs without waiting for `clk`.
- The first operation is honoured at the first rising edge with `rst` already high.

**Output stability**
- `Q` holds its last popped value through pushes and idle cycles.

## Test plan

- **Reset:** drive `rst` low for 2 ns mid-cycle → immediately `Q` = 0x00, `count` = 0, `empty` = 1, `full` = 0, `err` = 0.
- **LIFO order:** push 0x11, 0x22, 0x33 on consecutive edges (`count` = 3), then pop three times → `Q` = 0x33, 0x22, 0x11 after successive edges; `empty` = 1 and `err` = 0 at the end.
- **Full and overflow:** push 0..15 → `full` = 1, `count` = 16; push 0xAA → `count` stays 16 and `err` = 1; pop → `Q` = 0x0F (not 0xAA).
- **Underflow:** after reset, pop once → `Q` = 0x00, `count` = 0, `err` = 1; then push 0x05 and pop → `Q` = 0x05 with `err` still 1.
- **Simultaneous push/pop:**
  - With 0x44 stacked, `push` = `pop` = 1 with `D` = 0x55 → `Q` = 0x44, `count` = 1; a following pop gives `Q` = 0x55.
  - With the stack empty, `push` = `pop` = 1 with `D` = 0x66 → `Q` = 0x66, `count` = 0, `err` = 0.
- **Loop with mid-run reset:** push `i` = 0..9 and check `count` = `i+1` after each edge; assert reset at `count` = 10 → `count` = 0 immediately; the next pop sets `err` = 1.

Source files
------------

// File: rtl/lifo_stack.sv
// lifo_stack
// Parameterised LIFO stack with a registered pop output. It holds return
// addresses and operand spills for the FRANK6000 datapath.
//
// Ports
//   clk   : clock, rising edge active
//   rst   : asynchronous active-low reset (clears pointer, Q and err)
//   D     : data word to push
//   push  : push request, consumed at the sampling edge
//   pop   : pop request, consumed at the sampling edge
//   Q     : registered popped word, holds until the next pop or swap
//   count : number of stored entries, 0..depth
//   empty : count == 0
//   full  : count == depth
//   err   : sticky overflow/underflow flag, cleared only by reset
module lifo_stack #(
  parameter int width      = 8,
  parameter int depth      = 16,
  parameter int addr_width = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [width-1:0]      D,
  input  logic                  push,
  input  logic                  pop,
  output logic [width-1:0]      Q,
  output logic [addr_width:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic                  err
);

  localparam logic [addr_width:0]   spOne     = (addr_width+1)'(1);
  localparam logic [addr_width:0]   spFull    = (addr_width+1)'(depth);
  localparam logic [addr_width-1:0] idxOne    = addr_width'(1);

  logic [width-1:0]      mem [depth];

  logic [addr_width:0]   spQ, spD;
  logic [width-1:0]      qQ, qD;
  logic                  errQ, errD;

  logic                  memWe;
  logic [addr_width-1:0] memAddr;
  logic [addr_width-1:0] topIdx;
  logic                  isEmpty, isFull;

  // Index of the current top entry. When sp == depth the low bits are zero
  // and the subtraction wraps to depth-1, which is exactly the top slot.
  // The value is only consumed when the stack is not empty.
  assign topIdx  = spQ[addr_width-1:0] - idxOne;

  assign isEmpty = (spQ == '0);
  assign isFull  = (spQ == spFull);

  assign Q     = qQ;
  assign count = spQ;
  assign empty = isEmpty;
  assign full  = isFull;
  assign err   = errQ;

  always_comb begin
    spD     = spQ;
    qD      = qQ;
    errD    = errQ;
    memWe   = 1'b0;
    memAddr = spQ[addr_width-1:0];

    unique case ({push, pop})
      2'b10: begin
        if (isFull) begin
          errD = 1'b1;
        end else begin
          memWe   = 1'b1;
          memAddr = spQ[addr_width-1:0];
          spD     = spQ + spOne;
        end
      end
      2'b01: begin
        if (isEmpty) begin
          errD = 1'b1;
        end else begin
          qD  = mem[topIdx];
          spD = spQ - spOne;
        end
      end
      2'b11: begin
        // Swap replaces the top in place; on an empty stack the word
        // simply passes straight through to Q without touching memory.
        if (isEmpty) begin
          qD = D;
        end else begin
          qD      = mem[topIdx];
          memWe   = 1'b1;
          memAddr = topIdx;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      spQ  <= '0;
      qQ   <= '0;
      errQ <= 1'b0;
    end else begin
      spQ  <= spD;
      qQ   <= qD;
      errQ <= errD;
    end
  end

  // Storage is deliberately left out of reset; the pointer alone defines
  // which entries are valid.
  always_ff @(posedge clk) begin
    if (memWe) begin
      mem[memAddr] <= D;
    end
  end

endmodule

// File: tb/tb_lifo_stack.sv
// Testbench for lifo_stack: directed scenarios followed by randomized
// push/pop/swap traffic, all compared against a queue-based stack model.
module tb_lifo_stack;

  localparam int Width     = 8;
  localparam int Depth     = 16;
  localparam int AddrWidth = 4;

  logic                 clk;
  logic                 rst;
  logic [Width-1:0]     dIn;
  logic                 pushReq;
  logic                 popReq;
  logic [Width-1:0]     qOut;
  logic [AddrWidth:0]   countOut;
  logic                 emptyOut;
  logic                 fullOut;
  logic                 errOut;

  int testsRun  = 0;
  int failCount = 0;

  // Reference model: a plain queue used as a stack, plus Q and sticky err.
  logic [Width-1:0] model[$];
  logic [Width-1:0] refQ;
  logic             refErr;

  lifo_stack #(
    .width     (Width),
    .depth     (Depth),
    .addr_width(AddrWidth)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .D    (dIn),
    .push (pushReq),
    .pop  (popReq),
    .Q    (qOut),
    .count(countOut),
    .empty(emptyOut),
    .full (fullOut),
    .err  (errOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, "_Q"},     32'(qOut),     32'(refQ));
    checkOutput({tag, "_count"}, 32'(countOut), 32'(model.size()));
    checkOutput({tag, "_empty"}, 32'(emptyOut), 32'(model.size() == 0));
    checkOutput({tag, "_full"},  32'(fullOut),  32'(model.size() == Depth));
    checkOutput({tag, "_err"},   32'(errOut),   32'(refErr));
  endtask

  // Stack semantics computed straight from the operation rules.
  task automatic modelStep(input logic p, input logic o, input logic [Width-1:0] d);
    if (p && !o) begin
      if (model.size() == Depth) refErr = 1'b1;
      else model.push_back(d);
    end else if (!p && o) begin
      if (model.size() == 0) refErr = 1'b1;
      else refQ = model.pop_back();
    end else if (p && o) begin
      if (model.size() == 0) begin
        refQ = d;
      end else begin
        refQ = model[model.size()-1];
        model[model.size()-1] = d;
      end
    end
  endtask

  task automatic applyStimulus(input string tag, input logic p, input logic o,
                               input logic [Width-1:0] d);
    @(negedge clk);
    pushReq = p;
    popReq  = o;
    dIn     = d;
    @(posedge clk);
    modelStep(p, o, d);
    #1;
    pushReq = 1'b0;
    popReq  = 1'b0;
    checkAll(tag);
  endtask

  // Asynchronous reset pulse of 2 ns placed mid-cycle, checked immediately.
  task automatic doReset(input string tag);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    model.delete();
    refQ   = '0;
    refErr = 1'b0;
    checkAll(tag);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    rst     = 1'b0;
    pushReq = 1'b0;
    popReq  = 1'b0;
    dIn     = '0;
    refQ    = '0;
    refErr  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    doReset("reset");

    // LIFO order
    applyStimulus("lifo_push", 1'b1, 1'b0, 8'h11);
    applyStimulus("lifo_push", 1'b1, 1'b0, 8'h22);
    applyStimulus("lifo_push", 1'b1, 1'b0, 8'h33);
    checkOutput("lifo_count3", 32'(countOut), 32'd3);
    applyStimulus("lifo_pop", 1'b0, 1'b1, 8'h00);
    checkOutput("lifo_q33", 32'(qOut), 32'h33);
    applyStimulus("lifo_pop", 1'b0, 1'b1, 8'h00);
    checkOutput("lifo_q22", 32'(qOut), 32'h22);
    applyStimulus("lifo_pop", 1'b0, 1'b1, 8'h00);
    checkOutput("lifo_q11", 32'(qOut), 32'h11);

    // Full and overflow
    for (int i = 0; i < Depth; i++) applyStimulus("fill", 1'b1, 1'b0, 8'(i));
    checkOutput("full_flag", 32'(fullOut), 32'd1);
    applyStimulus("overflow", 1'b1, 1'b0, 8'hAA);
    checkOutput("overflow_err", 32'(errOut), 32'd1);
    checkOutput("overflow_count", 32'(countOut), 32'd16);
    applyStimulus("after_ovf_pop", 1'b0, 1'b1, 8'h00);
    checkOutput("after_ovf_q", 32'(qOut), 32'h0F);

    // Swap while full never sets err; refill first after a reset
    doReset("reset2");
    for (int i = 0; i < Depth; i++) applyStimulus("fill2", 1'b1, 1'b0, 8'(8'h80 + i));
    applyStimulus("swap_full", 1'b1, 1'b1, 8'hC3);
    checkOutput("swap_full_q", 32'(qOut), 32'h8F);
    applyStimulus("swap_full_pop", 1'b0, 1'b1, 8'h00);
    checkOutput("swap_full_new", 32'(qOut), 32'hC3);

    // Underflow
    doReset("reset3");
    applyStimulus("underflow", 1'b0, 1'b1, 8'h00);
    checkOutput("underflow_err", 32'(errOut), 32'd1);
    applyStimulus("uf_push", 1'b1, 1'b0, 8'h05);
    applyStimulus("uf_pop", 1'b0, 1'b1, 8'h00);
    checkOutput("uf_q05", 32'(qOut), 32'h05);

    // Simultaneous push/pop
    doReset("reset4");
    applyStimulus("sw_push", 1'b1, 1'b0, 8'h44);
    applyStimulus("swap", 1'b1, 1'b1, 8'h55);
    checkOutput("swap_q44", 32'(qOut), 32'h44);
    applyStimulus("swap_pop", 1'b0, 1'b1, 8'h00);
    checkOutput("swap_q55", 32'(qOut), 32'h55);
    applyStimulus("passthru", 1'b1, 1'b1, 8'h66);
    checkOutput("passthru_q", 32'(qOut), 32'h66);
    checkOutput("passthru_err", 32'(errOut), 32'd0);

    // Loop with mid-run reset
    for (int i = 0; i < 10; i++) begin
      applyStimulus("loop_push", 1'b1, 1'b0, 8'(i));
      checkOutput("loop_count", 32'(countOut), 32'(i + 1));
    end
    doReset("loop_reset");
    applyStimulus("loop_pop_err", 1'b0, 1'b1, 8'h00);
    checkOutput("loop_err", 32'(errOut), 32'd1);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      int sel;
      logic [Width-1:0] d;
      sel = int'($urandom_range(0, 9));
      d   = Width'($urandom);
      if ($urandom_range(0, 99) == 0) doReset("rand_reset");
      case (sel)
        0, 1, 2, 3: applyStimulus("rand_push", 1'b1, 1'b0, d);
        4, 5, 6:    applyStimulus("rand_pop",  1'b0, 1'b1, d);
        7, 8:       applyStimulus("rand_swap", 1'b1, 1'b1, d);
        default:    applyStimulus("rand_idle", 1'b0, 1'b0, d);
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
